// File: rtl/tx_transmisor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tx_transmisor_pkg
// Purpose : Shared constants for the tx_transmisor transmit datapath.
//           These are the datapath widths, the control_dk select codes and the
//           nominal K-symbol byte values.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package tx_transmisor_pkg;

   // Datapath geometry
   localparam int DATA_W    = 8;
   localparam int NUM_LANES = 4;
   localparam int PTR_W     = $clog2(NUM_LANES);

   // control_dk select codes
   localparam logic [3:0] CTL_DATA = 4'h0;
   localparam logic [3:0] CTL_COM  = 4'h1;
   localparam logic [3:0] CTL_SKP  = 4'h2;
   localparam logic [3:0] CTL_STP  = 4'h3;
   localparam logic [3:0] CTL_SDP  = 4'h4;
   localparam logic [3:0] CTL_END  = 4'h5;
   localparam logic [3:0] CTL_EDB  = 4'h6;
   localparam logic [3:0] CTL_FTS  = 4'h7;
   localparam logic [3:0] CTL_IDLE = 4'h8;

   // Nominal K-symbol byte values
   localparam logic [DATA_W-1:0] COM  = 8'hBC;
   localparam logic [DATA_W-1:0] SKP  = 8'h1C;
   localparam logic [DATA_W-1:0] STP  = 8'hFB;
   localparam logic [DATA_W-1:0] SDP  = 8'h5C;
   localparam logic [DATA_W-1:0] END  = 8'hFD;
   localparam logic [DATA_W-1:0] EDB  = 8'hFE;
   localparam logic [DATA_W-1:0] FTS  = 8'h3C;
   localparam logic [DATA_W-1:0] IDLE = 8'h7C;

endpackage : tx_transmisor_pkg
`default_nettype wire

// File: rtl/tx_byte_stripe.sv
`default_nettype none
// ============================================================================
// Module  : tx_byte_stripe
// Purpose : Stage 2 of the transmit datapath. Writes each valid byte into the
//           lane addressed by a round-robin pointer, then advances the
//           pointer. Lanes that are not addressed hold their value.
// Ports   : clk             - rising-edge clock
//           rst             - synchronous reset, active-low
//           i_enb           - enable; when low pointer and lanes freeze
//           i_valid         - i_data carries a byte to stripe
//           i_data          - byte from the symbol mux
//           o_lane0..o_lane3- lane registers
// Revision: 1.0 - initial release
// ============================================================================
module tx_byte_stripe
   import tx_transmisor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enb,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_lane0,
   output logic [DATA_W-1:0] o_lane1,
   output logic [DATA_W-1:0] o_lane2,
   output logic [DATA_W-1:0] o_lane3
);

   logic [PTR_W-1:0]  r_ptr;
   logic [DATA_W-1:0] r_lane [NUM_LANES];

   // The pointer counts valid bytes only; symbol type never realigns it, and
   // it wraps naturally because its width is log2 of the lane count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            r_lane[i] <= '0;
         end
      end else if (i_enb && i_valid) begin
         r_lane[r_ptr] <= i_data;
         r_ptr         <= r_ptr + PTR_W'(1);
      end
   end

   assign o_lane0 = r_lane[0];
   assign o_lane1 = r_lane[1];
   assign o_lane2 = r_lane[2];
   assign o_lane3 = r_lane[3];

endmodule : tx_byte_stripe
`default_nettype wire

// File: rtl/tx_symbol_mux.sv
`default_nettype none
// ============================================================================
// Module  : tx_symbol_mux
// Purpose : Stage 1 of the transmit datapath. Selects the payload byte or one
//           of eight K-symbol bytes from a 4-bit control code and registers
//           the result with a valid flag.
// Ports   : clk          - rising-edge clock
//           rst          - synchronous reset, active-low
//           i_enb        - enable; when low the byte holds and valid drops
//           i_tx_data    - payload byte (code 0000)
//           i_com..i_idle- K-symbol byte values (codes 0001..1000)
//           i_control_dk - select code; unused codes map to i_idle
//           o_mux_q      - registered selected byte
//           o_valid_q    - high when o_mux_q was loaded on the last edge
// Revision: 1.0 - initial release
// ============================================================================
module tx_symbol_mux
   import tx_transmisor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enb,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic [DATA_W-1:0] i_com,
   input  logic [DATA_W-1:0] i_skp,
   input  logic [DATA_W-1:0] i_stp,
   input  logic [DATA_W-1:0] i_sdp,
   input  logic [DATA_W-1:0] i_end_ok,
   input  logic [DATA_W-1:0] i_edb,
   input  logic [DATA_W-1:0] i_fts,
   input  logic [DATA_W-1:0] i_idle,
   input  logic [3:0]        i_control_dk,
   output logic [DATA_W-1:0] o_mux_q,
   output logic              o_valid_q
);

   logic [DATA_W-1:0] w_sel;
   logic [DATA_W-1:0] r_mux_q;
   logic              r_valid_q;

   // Reserved codes and unknown selects all fall through to the idle symbol.
   always_comb begin
      w_sel = i_idle;
      case (i_control_dk)
         CTL_DATA: w_sel = i_tx_data;
         CTL_COM:  w_sel = i_com;
         CTL_SKP:  w_sel = i_skp;
         CTL_STP:  w_sel = i_stp;
         CTL_SDP:  w_sel = i_sdp;
         CTL_END:  w_sel = i_end_ok;
         CTL_EDB:  w_sel = i_edb;
         CTL_FTS:  w_sel = i_fts;
         CTL_IDLE: w_sel = i_idle;
         default:  w_sel = i_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mux_q   <= '0;
         r_valid_q <= 1'b0;
      end else if (i_enb) begin
         r_mux_q   <= w_sel;
         r_valid_q <= 1'b1;
      end else begin
         r_valid_q <= 1'b0;
      end
   end

   assign o_mux_q   = r_mux_q;
   assign o_valid_q = r_valid_q;

endmodule : tx_symbol_mux
`default_nettype wire

// File: rtl/tx_transmisor.sv
`default_nettype none
// ============================================================================
// Module  : tx_transmisor
// Purpose : Transmit-side datapath of a 4-lane link. A registered symbol mux
//           feeds a round-robin byte striper. Input to lane latency is two
//           clock edges.
// Ports   : clk          - rising-edge clock
//           rst          - synchronous reset, active-low
//           enb          - global enable; when low both stages hold
//           tx_Data      - payload byte
//           com..idle    - K-symbol byte values
//           control_dk   - data/K-symbol select code
//           tx_lane0..3  - striped lane bytes
// Revision: 1.0 - initial release
// ============================================================================
module tx_transmisor
   import tx_transmisor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic [DATA_W-1:0] tx_Data,
   input  logic [DATA_W-1:0] com,
   input  logic [DATA_W-1:0] skp,
   input  logic [DATA_W-1:0] stp,
   input  logic [DATA_W-1:0] sdp,
   input  logic [DATA_W-1:0] end_ok,
   input  logic [DATA_W-1:0] edb,
   input  logic [DATA_W-1:0] fts,
   input  logic [DATA_W-1:0] idle,
   input  logic [3:0]        control_dk,
   output logic [DATA_W-1:0] tx_lane0,
   output logic [DATA_W-1:0] tx_lane1,
   output logic [DATA_W-1:0] tx_lane2,
   output logic [DATA_W-1:0] tx_lane3
);

   logic [DATA_W-1:0] tx_mux_out;
   logic              tx_Valid;

   tx_symbol_mux u_mux (
      .clk          (clk),
      .rst          (rst),
      .i_enb        (enb),
      .i_tx_data    (tx_Data),
      .i_com        (com),
      .i_skp        (skp),
      .i_stp        (stp),
      .i_sdp        (sdp),
      .i_end_ok     (end_ok),
      .i_edb        (edb),
      .i_fts        (fts),
      .i_idle       (idle),
      .i_control_dk (control_dk),
      .o_mux_q      (tx_mux_out),
      .o_valid_q    (tx_Valid)
   );

   tx_byte_stripe u_stripe (
      .clk     (clk),
      .rst     (rst),
      .i_enb   (enb),
      .i_valid (tx_Valid),
      .i_data  (tx_mux_out),
      .o_lane0 (tx_lane0),
      .o_lane1 (tx_lane1),
      .o_lane2 (tx_lane2),
      .o_lane3 (tx_lane3)
   );

endmodule : tx_transmisor
`default_nettype wire

// File: tb/tb_tx_transmisor.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_transmisor
// Purpose : Scoreboard bench for tx_transmisor. Stimulus pushes the expected
//           (lane, byte) for each byte that will reach a lane. A monitor pops
//           one entry on every lane write and compares all four lanes against
//           its expected lane image.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tx_transmisor;
   import tx_transmisor_pkg::*;

   logic       clk = 1'b0;
   logic       rst, enb;
   logic [7:0] tx_Data, com, skp, stp, sdp, end_ok, edb, fts, idle;
   logic [3:0] control_dk;
   logic [7:0] tx_lane0, tx_lane1, tx_lane2, tx_lane3;

   always #5 clk = ~clk;

   tx_transmisor dut (
      .clk        (clk),
      .rst        (rst),
      .enb        (enb),
      .tx_Data    (tx_Data),
      .com        (com),
      .skp        (skp),
      .stp        (stp),
      .sdp        (sdp),
      .end_ok     (end_ok),
      .edb        (edb),
      .fts        (fts),
      .idle       (idle),
      .control_dk (control_dk),
      .tx_lane0   (tx_lane0),
      .tx_lane1   (tx_lane1),
      .tx_lane2   (tx_lane2),
      .tx_lane3   (tx_lane3)
   );

   typedef struct packed {
      logic [1:0] lane;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- monitor ----------------
   // Edge-level model of when the striper writes: a byte sampled with enb=1
   // is written on the next edge only if enb is still 1 and no reset occurs.
   logic m_valid  = 1'b0;
   logic m_strobe = 1'b0;
   logic m_rst    = 1'b0;
   logic m_armed  = 1'b0;
   logic [7:0] img [4];

   initial begin
      forever begin
         @(posedge clk);
         if (!rst) begin
            m_strobe = 1'b0;
            m_valid  = 1'b0;
            m_rst    = 1'b1;
         end else begin
            m_strobe = m_valid & enb;
            m_valid  = enb;
            m_rst    = 1'b0;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_rst) begin
            m_armed = 1'b1;
            for (int i = 0; i < 4; i++) img[i] = 8'h00;
         end
         if (m_armed) begin
            if (m_strobe) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_write: got a lane write expected none at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  img[e.lane] = e.val;
               end
            end
            chk("lane0", {24'h0, tx_lane0}, {24'h0, img[0]});
            chk("lane1", {24'h0, tx_lane1}, {24'h0, img[1]});
            chk("lane2", {24'h0, tx_lane2}, {24'h0, img[2]});
            chk("lane3", {24'h0, tx_lane3}, {24'h0, img[3]});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic e, input logic [3:0] c, input logic [7:0] d);
      enb        = e;
      control_dk = c;
      tx_Data    = d;
      @(negedge clk);
   endtask

   task automatic sb_step(input logic [3:0] c, input logic [7:0] d,
                          input int l, input logic [7:0] v);
      exp_t e;
      e.lane = 2'(l);
      e.val  = v;
      sb.push_back(e);
      step(1'b1, c, d);
   endtask

   task automatic nominal_symbols();
      com = COM; skp = SKP; stp = STP; sdp = SDP;
      end_ok = END; edb = EDB; fts = FTS; idle = IDLE;
   endtask

   initial begin
      nominal_symbols();
      rst = 1'b0;
      // Reset with arbitrary select/data
      step(1'b1, 4'($urandom), 8'($urandom));
      step(1'b1, 4'($urandom), 8'($urandom));
      chk("rst_lane0", {24'h0, tx_lane0}, 32'h0);
      chk("rst_lane1", {24'h0, tx_lane1}, 32'h0);
      chk("rst_lane2", {24'h0, tx_lane2}, 32'h0);
      chk("rst_lane3", {24'h0, tx_lane3}, 32'h0);
      rst = 1'b1;

      // IDLE x4
      for (int i = 0; i < 4; i++) sb_step(CTL_IDLE, 8'h00, i, 8'h7C);
      // COM x4, STP, DATA FF x2, END
      for (int i = 0; i < 4; i++) sb_step(CTL_COM, 8'h00, i, 8'hBC);
      sb_step(CTL_STP,  8'h00, 0, 8'hFB);
      sb_step(CTL_DATA, 8'hFF, 1, 8'hFF);
      sb_step(CTL_DATA, 8'hFF, 2, 8'hFF);
      sb_step(CTL_END,  8'h00, 3, 8'hFD);
      // SKP x12 then STP lands on lane0 after three wraps
      for (int i = 0; i < 12; i++) sb_step(CTL_SKP, 8'h00, i % 4, 8'h1C);
      sb_step(CTL_STP, 8'h00, 0, 8'hFB);

      // Enable drop: 33 is sampled but enb falls before it is striped
      sb_step(CTL_DATA, 8'h11, 1, 8'h11);
      sb_step(CTL_DATA, 8'h22, 2, 8'h22);
      step(1'b1, CTL_DATA, 8'h33);
      for (int i = 0; i < 3; i++) step(1'b0, CTL_COM, 8'h00);
      sb_step(CTL_DATA, 8'h44, 3, 8'h44);

      // Reserved code maps to idle
      sb_step(4'hB, 8'h00, 0, 8'h7C);
      // Unknown code: a two-state simulator resolves X to some code, so every
      // source carries 7C to keep the expected byte well defined.
      tx_Data = 8'h7C; com = 8'h7C; skp = 8'h7C; stp = 8'h7C;
      sdp = 8'h7C; end_ok = 8'h7C; edb = 8'h7C; fts = 8'h7C; idle = 8'h7C;
      sb_step(4'bxxxx, 8'h7C, 1, 8'h7C);
      nominal_symbols();
      idle = 8'hAA;
      sb_step(CTL_IDLE, 8'h00, 2, 8'hAA);
      sb_step(4'hF,     8'h00, 3, 8'hAA);
      idle = IDLE;

      // Mid-stream reset discards the pending 55 and rewinds the pointer
      sb_step(CTL_DATA, 8'h99, 0, 8'h99);
      step(1'b1, CTL_DATA, 8'h55);
      rst = 1'b0;
      step(1'b1, CTL_DATA, 8'h12);
      rst = 1'b1;
      sb_step(CTL_DATA, 8'h66, 0, 8'h66);
      sb_step(CTL_DATA, 8'h77, 1, 8'h77);
      step(1'b1, CTL_DATA, 8'h88);
      for (int i = 0; i < 4; i++) step(1'b0, CTL_DATA, 8'h00);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_tx_transmisor
`default_nettype wire
